seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 147 ++++++++++++++
 tb/tb_seg_display_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed 7-segment driver with a serial double-dabble converter.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
`timescale 1ns/1ps
module seg_display_driver #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] displayedNum,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        ovf
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   val_q, cap_q, committed_q, digits_q;
    logic [39:0]   bcd_q, bcd_next;
    logic [4:0]    iter_q;
    logic          ovf_q;
    logic [CW-1:0] rcnt_q;
    logic [2:0]    idx_q;
    logic [3:0]    nib, cur;
    logic [7:0]    blank;
    logic          mismatch;

    assign mismatch = (displayedNum != committed_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mismatch) state_d = CONVERT;
            CONVERT: if (iter_q == 5'd31) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next bit.
    always_comb begin
        bcd_next    = '0;
        bcd_next[0] = cap_q[31];
        nib         = '0;
        for (int i = 0; i < 9; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_next[4*i+1 +: 4] = nib;
        end
        nib = bcd_q[39:36];
        if (nib >= 4'd5) nib = nib + 4'd3;
        bcd_next[39:37] = nib[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q       <= '0;
            cap_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            committed_q <= '0;
            digits_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mismatch) begin
                        val_q  <= displayedNum;
                        cap_q  <= displayedNum;
                        bcd_q  <= '0;
                        iter_q <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q  <= bcd_next;
                    cap_q  <= {cap_q[30:0], 1'b0};
                    iter_q <= iter_q + 5'd1;
                end
                COMMIT: begin
                    digits_q    <= bcd_q[31:0];
                    committed_q <= val_q;
                    ovf_q       <= |bcd_q[39:32];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            idx_q  <= '0;
        end else if (rcnt_q == CW'(REFRESH_DIV - 1)) begin
            rcnt_q <= '0;
            idx_q  <= idx_q + 3'd1;
        end else begin
            rcnt_q <= rcnt_q + CW'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic run;
    always_comb begin
        blank = '0;
        run   = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            run      = run & (digits_q[4*k +: 4] == 4'd0);
            blank[k] = run;
        end
    end
`else
    assign blank = '0;
`endif

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    assign cur  = digits_q[{idx_q, 2'b00} +: 4];
    assign an   = ~(8'd1 << idx_q);
    assign seg  = ovf_q ? 7'h3F : (blank[idx_q] ? 7'h7F : enc(cur));
    assign dp   = 1'b1;
    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver with REFRESH_DIV=4.
`timescale 1ns/1ps
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] num = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp, busy, ovf;
    int          errors = 0;
    int          checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'h7F;
`else
    localparam logic [6:0] ZB = 7'h40;
`endif

    seg_display_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .displayedNum(num),
        .an(an), .seg(seg), .dp(dp), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_an(input logic [7:0] t, input string tag);
        int n = 0;
        while (an !== t && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (an !== t) chk({tag, " an timeout"}, {24'd0, an}, {24'd0, t});
    endtask

    task automatic scan(input string tag, input logic [55:0] e);
        logic [7:0] ea;
        wait_an(8'hFE, tag);
        for (int k = 0; k < 8; k++) begin
            ea = ~(8'd1 << k);
            chk($sformatf("%s an%0d", tag, k), {24'd0, an}, {24'd0, ea});
            chk($sformatf("%s seg%0d", tag, k), {25'd0, seg},
                {25'd0, e[7*k +: 7]});
            repeat (4) @(negedge clk);
        end
        chk({tag, " wrap"}, {24'd0, an}, 32'hFE);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, f1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("scan_pre", {24'd0, an}, 32'hFD);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_dp", {31'd0, dp}, 32'd1);

        @(negedge clk);
        num = 32'd5;
        rst_n = 1'b1;
        @(negedge clk);
        chk("one_busy_rise", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("one_busy_len", n, 32'd33);
        chk("one_ovf", {31'd0, ovf}, 32'd0);
        scan("one", {ZB, ZB, ZB, ZB, ZB, ZB, ZB, 7'h12});

        @(negedge clk);
        num = 32'd12_345_678;
        wait_done("full");
        scan("full", {7'h79, 7'h24, 7'h30, 7'h19,
                      7'h12, 7'h02, 7'h78, 7'h00});

        @(negedge clk);
        num = 32'd100_000_000;
        wait_done("ovf");
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        scan("ovf", {8{7'h3F}});

        @(negedge clk);
        num = 32'd99_999_999;
        wait_done("nines");
        chk("ovf_clr", {31'd0, ovf}, 32'd0);
        scan("nines", {8{7'h10}});

        @(negedge clk);
        num = 32'd5;
        @(negedge clk);
        chk("mid_busy_rise", {31'd0, busy}, 32'd1);
        n = 0;
        f1 = 0;
        while (n < 120) begin
            @(negedge clk);
            n++;
            if (n == 10) num = 32'd9;
            if (!busy && f1 == 0) f1 = n;
            else if (!busy && f1 != 0 && n > f1 + 1) break;
        end
        chk("mid_first_commit", f1, 32'd33);
        chk("mid_second_commit", n, 32'd67);
        scan("mid", {ZB, ZB, ZB, ZB, ZB, ZB, ZB, 7'h10});

        @(negedge clk);
        num = 32'd42;
        @(negedge clk);
        chk("abort_busy_rise", {31'd0, busy}, 32'd1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_seg", {25'd0, seg}, 32'h40);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_restart", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("abort_busy_len", n, 32'd33);
        scan("abort", {ZB, ZB, ZB, ZB, ZB, ZB, 7'h19, 7'h24});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
